// File: rtl/duv_share_ctrl_if.sv
// Bundle between the round-robin DUV share controller and its environment:
// the requester agents on one side and the shared DUV datapath on the other.
interface duv_share_ctrl_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    // requester side
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] cmd;
    logic [N_REQ-1:0]   gnt;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [7:0]         rsp_data;
    logic               busy;

    // DUV side
    logic               duv_in_a;
    logic               duv_in_b;
    logic [1:0]         duv_out_a;
    logic [1:0]         duv_out_b;
    logic [1:0]         duv_out_c;
    logic [1:0]         duv_out_d;

    // controller view
    modport slave (
        input  req, cmd, duv_out_a, duv_out_b, duv_out_c, duv_out_d,
        output gnt, rsp_valid, rsp_id, rsp_data, busy, duv_in_a, duv_in_b
    );

    // environment view: requesters plus the DUV instance
    modport master (
        output req, cmd, duv_out_a, duv_out_b, duv_out_c, duv_out_d,
        input  gnt, rsp_valid, rsp_id, rsp_data, busy, duv_in_a, duv_in_b
    );
endinterface

// File: rtl/duv_share_ctrl.sv
// Round-robin controller sharing one DUV datapath between N_REQ requesters.
// A grant drives the winner's 2-bit command onto the DUV for HOLD_CYC cycles,
// waits LAT_CYC cycles, captures the four DUV results and returns them with
// the winner's ID.
module duv_share_ctrl #(
    parameter int N_REQ    = 4,
    parameter int HOLD_CYC = 2,
    parameter int LAT_CYC  = 2
) (
    input  logic            clk,
    input  logic            arst,
    duv_share_ctrl_if.slave bus
);
    localparam int IDW     = $clog2(N_REQ);
    localparam int CNT_MAX = (HOLD_CYC > LAT_CYC) ? HOLD_CYC : LAT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [N_REQ-1:0] gnt, gnt_nxt;
    logic             in_a, in_a_nxt;
    logic             in_b, in_b_nxt;
    logic             rsp_valid, rsp_valid_nxt;
    logic [IDW-1:0]   rsp_id, rsp_id_nxt;
    logic [7:0]       rsp_data, rsp_data_nxt;

    logic             found;
    logic [IDW-1:0]   winner;
    logic [IDW:0]     idx;
    logic [1:0]       cmd_sel;

    // Round-robin search: first requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N_REQ)) begin
                idx = idx - (IDW+1)'(N_REQ);
            end
            if (!found && bus.req[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
        cmd_sel = bus.cmd[2*winner +: 2];
    end

    // Next-state and next-output logic; req/cmd only matter in IDLE.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ptr_nxt       = ptr;
        gnt_nxt       = '0;
        in_a_nxt      = in_a;
        in_b_nxt      = in_b;
        rsp_valid_nxt = 1'b0;
        rsp_id_nxt    = rsp_id;
        rsp_data_nxt  = rsp_data;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt       = DRIVE;
                    cnt_nxt         = CNT_W'(HOLD_CYC - 1);
                    ptr_nxt         = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    gnt_nxt[winner] = 1'b1;
                    in_a_nxt        = cmd_sel[0];
                    in_b_nxt        = cmd_sel[1];
                    rsp_id_nxt      = winner;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    in_a_nxt  = 1'b0;
                    in_b_nxt  = 1'b0;
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(LAT_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    rsp_data_nxt  = {bus.duv_out_d, bus.duv_out_c, bus.duv_out_b, bus.duv_out_a};
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gnt       <= '0;
            in_a      <= 1'b0;
            in_b      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            in_a      <= in_a_nxt;
            in_b      <= in_b_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.duv_in_a  = in_a;
    assign bus.duv_in_b  = in_b;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_data;
    assign bus.busy      = (state != IDLE);
endmodule
